// File: rtl/rom_sequencer_pkg.sv
// Shared definitions for the ROM read sequencer: default geometry and FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rom_sequencer_pkg;

    localparam int ROM_AW = 4;
    localparam int ROM_DW = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/rom_sequencer_if.sv
// Bundle of control, ROM-side and output-stream signals of the ROM sequencer.
// Latency: n/a (wiring only).
// Backpressure: out_ready from the consumer stalls the output stream.
interface rom_sequencer_if
    import rom_sequencer_pkg::*;
#(
    parameter int AW = ROM_AW,
    parameter int DW = ROM_DW
);
    logic          start;
    logic [AW-1:0] first_addr;
    logic [AW-1:0] last_addr;
    logic          busy;
    logic          done;
    logic [AW-1:0] rom_addr;
    logic          rom_en;
    logic          rom_ce;
    logic [DW-1:0] rom_data;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;

    // Sequencer side.
    modport master (
        input  start, first_addr, last_addr, rom_data, out_ready,
        output busy, done, rom_addr, rom_en, rom_ce, out_data, out_valid, out_last
    );

    // Requester / ROM / consumer side.
    modport slave (
        output start, first_addr, last_addr, rom_data, out_ready,
        input  busy, done, rom_addr, rom_en, rom_ce, out_data, out_valid, out_last
    );

endinterface

// File: rtl/rom_addr_ctr.sv
// Loadable wrapping address counter; remembers the sweep's last address.
// Latency: addr updates one edge after load/inc; at_last is combinational on addr.
// Backpressure: holds whenever inc is low.
module rom_addr_ctr #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [AW-1:0] load_val,
    input  logic [AW-1:0] last_val,
    input  logic          inc,
    output logic [AW-1:0] addr,
    output logic          at_last
);
    logic [AW-1:0] last_q;

    // Load start/end bounds together; otherwise step by one with natural wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr   <= '0;
            last_q <= '0;
        end else if (load) begin
            addr   <= load_val;
            last_q <= last_val;
        end else if (inc) begin
            addr   <= addr + AW'(1);
        end
    end

    assign at_last = (addr == last_q);

endmodule

// File: rtl/rom_sequencer.sv
// Sweeps ROM addresses first..last (wrapping) and streams the words out.
// Latency: start -> first out_valid is 2 edges; 1 word/cycle when out_ready stays high.
// Backpressure: out_ready low freezes rom_addr and the output register, no bubbles.
module rom_sequencer
    import rom_sequencer_pkg::*;
#(
    parameter int AW = ROM_AW,
    parameter int DW = ROM_DW
) (
    input  logic            clk,
    input  logic            rst,
    rom_sequencer_if.master bus
);
    state_t        state;
    logic          busy_q;
    logic          done_q;
    logic          rom_en_q;
    logic          rom_ce_q;
    logic [DW-1:0] out_data_q;
    logic          out_valid_q;
    logic          out_last_q;

    logic [AW-1:0] addr;
    logic          at_last;
    logic          capture;
    logic          accept_last;
    logic          ctr_load;
    logic          ctr_inc;
    logic [AW-1:0] ld_first;
    logic [AW-1:0] ld_last;

    // Output register may take a new word when empty or being drained this cycle.
    assign capture     = !out_valid_q || bus.out_ready;
    assign accept_last = out_valid_q && bus.out_ready && out_last_q;

    rom_addr_ctr #(.AW(AW)) u_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (ctr_load),
        .load_val (ld_first),
        .last_val (ld_last),
        .inc      (ctr_inc),
        .addr     (addr),
        .at_last  (at_last)
    );

    // Counter control: latch bounds on start, advance on each non-final capture,
    // and park the address back at zero when the sweep completes.
    always_comb begin
        ctr_load = 1'b0;
        ctr_inc  = 1'b0;
        ld_first = '0;
        ld_last  = '0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    ctr_load = 1'b1;
                    ld_first = bus.first_addr;
                    ld_last  = bus.last_addr;
                end
            end
            ST_READ:  ctr_inc  = capture && !at_last;
            ST_DRAIN: ctr_load = accept_last;
            default:  ;
        endcase
    end

    // Sweep FSM with registered status, ROM strobes and output stream register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rom_en_q    <= 1'b0;
            rom_ce_q    <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        busy_q   <= 1'b1;
                        rom_en_q <= 1'b1;
                        rom_ce_q <= 1'b1;
                        state    <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (capture) begin
                        out_data_q  <= bus.rom_data;
                        out_valid_q <= 1'b1;
                        out_last_q  <= at_last;
                        if (at_last) begin
                            rom_en_q <= 1'b0;
                            state    <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (accept_last) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        rom_ce_q    <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.rom_addr  = addr;
    assign bus.rom_en    = rom_en_q;
    assign bus.rom_ce    = rom_ce_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_rom_sequencer.sv
// Testbench for rom_sequencer: ROM table model, per-cycle reference model, directed + random sweeps.
// Latency: n/a.
// Backpressure: out_ready driven high, from a fixed pattern, or randomly.
module tb_rom_sequencer;
    import rom_sequencer_pkg::*;

    localparam int AW    = ROM_AW;
    localparam int DW    = ROM_DW;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // Free-running clock.
    always #5 clk = ~clk;

    rom_sequencer_if #(.AW(AW), .DW(DW)) bus ();

    rom_sequencer #(.AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ROM contents: high nibble = address, low nibble = 15 - address.
    logic [DW-1:0] rom_mem [DEPTH];
    assign bus.rom_data = (bus.rom_en && bus.rom_ce) ? rom_mem[bus.rom_addr] : 'x;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state: addresses of the current sweep not yet accepted.
    bit            m_known = 1'b0;
    bit            m_busy  = 1'b0;
    bit            m_done  = 1'b0;
    int            m_age   = 0;
    logic [DW-1:0] m_hold  = '0;
    int            q [$];

    // Observed accepted words, for literal checks.
    logic [DW-1:0] log_data [$];
    bit            log_last [$];
    int            done_cnt = 0;

    int ready_mode = 0;
    int bp_idx     = 0;
    bit bp_pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    // Consumer ready driver, changed a little after each rising edge.
    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = ($urandom_range(0, 3) != 0);
            default: begin
                bus.out_ready = (bp_idx < 7) ? bp_pat[bp_idx] : 1'b1;
                bp_idx++;
            end
        endcase
        if (ready_mode != 2) bp_idx = 0;
    end

    // Compare DUT against the model every cycle, then advance the model.
    always @(negedge clk) begin
        bit ev;
        bit ee;
        ev = m_busy && (m_age >= 1) && (q.size() > 0);
        ee = m_busy && ((q.size() - (ev ? 1 : 0)) > 0);
        if (m_known) begin
            check("busy",      32'(bus.busy),      32'(m_busy));
            check("done",      32'(bus.done),      32'(m_done));
            check("rom_ce",    32'(bus.rom_ce),    32'(m_busy));
            check("rom_en",    32'(bus.rom_en),    32'(ee));
            check("out_valid", 32'(bus.out_valid), 32'(ev));
            if (ee)
                check("rom_addr", 32'(bus.rom_addr), 32'(q[ev ? 1 : 0]));
            else if (!m_busy)
                check("rom_addr_idle", 32'(bus.rom_addr), 32'd0);
            if (ev) begin
                check("out_data", 32'(bus.out_data), 32'(rom_mem[q[0]]));
                check("out_last", 32'(bus.out_last), 32'(q.size() == 1));
            end else begin
                check("out_data_hold", 32'(bus.out_data), 32'(m_hold));
                check("out_last_idle", 32'(bus.out_last), 32'd0);
            end
        end
        if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            log_data.push_back(bus.out_data);
            log_last.push_back(bus.out_last);
        end
        if (bus.done === 1'b1) done_cnt++;

        if (rst) begin
            m_known = 1'b1;
            m_busy  = 1'b0;
            m_done  = 1'b0;
            m_age   = 0;
            m_hold  = '0;
            q.delete();
        end else if (m_known) begin
            m_done = 1'b0;
            if (m_busy) begin
                if (ev && bus.out_ready) begin
                    m_hold = rom_mem[q[0]];
                    void'(q.pop_front());
                    if (q.size() == 0) begin
                        m_busy = 1'b0;
                        m_done = 1'b1;
                    end
                end
                m_age++;
            end else if (bus.start) begin
                q.delete();
                for (int k = 0; k < DEPTH; k++) begin
                    int a;
                    a = (int'(bus.first_addr) + k) % DEPTH;
                    q.push_back(a);
                    if (a == int'(bus.last_addr)) break;
                end
                m_busy = 1'b1;
                m_age  = 0;
            end
        end
    end

    // Pulse start for one edge; called at #1 after a rising edge.
    task automatic do_start(input int f, input int l);
        bus.first_addr = AW'(f);
        bus.last_addr  = AW'(l);
        bus.start      = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Count edges until done is seen, with a bounded wait.
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (bus.done !== 1'b1 && n < 300);
        if (bus.done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL wait_done: no done after %0d cycles, required done=1", n);
        end
    endtask

    task automatic clear_log();
        log_data.delete();
        log_last.delete();
        done_cnt = 0;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"},      32'(bus.busy),      32'd0);
        check({tag, "_done"},      32'(bus.done),      32'd0);
        check({tag, "_rom_addr"},  32'(bus.rom_addr),  32'd0);
        check({tag, "_rom_en"},    32'(bus.rom_en),    32'd0);
        check({tag, "_rom_ce"},    32'(bus.rom_ce),    32'd0);
        check({tag, "_out_data"},  32'(bus.out_data),  32'd0);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_out_last"},  32'(bus.out_last),  32'd0);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < DEPTH; i++) rom_mem[i] = DW'(i * 16 + (15 - i));
        bus.start      = 1'b0;
        bus.first_addr = '0;
        bus.last_addr  = '0;
        ready_mode     = 0;
        rst            = 1'b1;

        // Reset held for 3 cycles.
        repeat (3) @(posedge clk);
        #1;
        check_idle_zero("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Full sweep 0..15 at full rate.
        clear_log();
        do_start(0, 15);
        wait_done(n);
        check("full_latency", 32'(n), 32'd17);
        @(posedge clk);
        #1;
        check("full_count", 32'(log_data.size()), 32'd16);
        for (int i = 0; i < 16 && i < log_data.size(); i++) begin
            check("full_word", 32'(log_data[i]), 32'(rom_mem[i]));
            check("full_last", 32'(log_last[i]), 32'(i == 15));
        end
        check("full_done_cnt", 32'(done_cnt), 32'd1);

        // Single word at address 7.
        clear_log();
        do_start(7, 7);
        wait_done(n);
        check("single_latency", 32'(n), 32'd2);
        @(posedge clk);
        #1;
        check("single_count", 32'(log_data.size()), 32'd1);
        if (log_data.size() >= 1) begin
            check("single_word", 32'(log_data[0]), 32'h78);
            check("single_last", 32'(log_last[0]), 32'd1);
        end
        check("single_done_cnt", 32'(done_cnt), 32'd1);

        // Wrap-around 14 -> 1.
        clear_log();
        do_start(14, 1);
        wait_done(n);
        check("wrap_latency", 32'(n), 32'd5);
        @(posedge clk);
        #1;
        check("wrap_count", 32'(log_data.size()), 32'd4);
        if (log_data.size() >= 4) begin
            check("wrap_w0", 32'(log_data[0]), 32'hE1);
            check("wrap_w1", 32'(log_data[1]), 32'hF0);
            check("wrap_w2", 32'(log_data[2]), 32'h0F);
            check("wrap_w3", 32'(log_data[3]), 32'h1E);
            check("wrap_last_early", 32'(log_last[2]), 32'd0);
            check("wrap_last", 32'(log_last[3]), 32'd1);
        end

        // Back-pressure pattern on sweep 0..3.
        clear_log();
        ready_mode = 2;
        do_start(0, 3);
        wait_done(n);
        ready_mode = 0;
        @(posedge clk);
        #1;
        check("bp_count", 32'(log_data.size()), 32'd4);
        if (log_data.size() >= 4) begin
            check("bp_w0", 32'(log_data[0]), 32'h0F);
            check("bp_w1", 32'(log_data[1]), 32'h1E);
            check("bp_w2", 32'(log_data[2]), 32'h2D);
            check("bp_w3", 32'(log_data[3]), 32'h3C);
        end
        check("bp_done_cnt", 32'(done_cnt), 32'd1);

        // Start with new bounds during a busy sweep is ignored.
        clear_log();
        ready_mode = 1;
        do_start(2, 9);
        repeat (3) @(posedge clk);
        #1;
        do_start(12, 13);
        wait_done(n);
        ready_mode = 0;
        repeat (4) @(posedge clk);
        #1;
        check("ign_count", 32'(log_data.size()), 32'd8);
        for (int i = 0; i < 8 && i < log_data.size(); i++)
            check("ign_word", 32'(log_data[i]), 32'(rom_mem[2 + i]));
        check("ign_done_cnt", 32'(done_cnt), 32'd1);

        // Reset mid-sweep: next cycle idle with zeros and no done.
        clear_log();
        do_start(0, 15);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_idle_zero("midrst");
        repeat (20) @(posedge clk);
        #1;
        check("midrst_done_cnt", 32'(done_cnt), 32'd0);

        // Random sweeps with random back-pressure and stray start pulses.
        ready_mode = 1;
        for (int s = 0; s < 30; s++) begin
            bus.first_addr = AW'($urandom_range(0, DEPTH - 1));
            bus.last_addr  = AW'($urandom_range(0, DEPTH - 1));
            bus.start      = 1'b1;
            n = 0;
            do begin
                @(posedge clk);
                #1;
                n++;
                if (bus.done === 1'b1) break;
                bus.start      = ($urandom_range(0, 9) == 0);
                bus.first_addr = AW'($urandom_range(0, DEPTH - 1));
                bus.last_addr  = AW'($urandom_range(0, DEPTH - 1));
            end while (n < 300);
            bus.start = 1'b0;
            if (bus.done !== 1'b1) begin
                checks++;
                errors++;
                $display("FAIL rand_timeout: sweep %0d no done, required done=1", s);
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        ready_mode = 0;
        repeat (3) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
